wb_msi_io_responder: RTL and testbench

Device-side Wishbone responder: the endpoint that one channel of the 256-bit I/O bridge talks to. It decodes requests on the bridge master port and serves a small 256-bit register file with byte-lane writes. It returns responses on the channel response bus. It also originates MSI interrupt messages: unsolicited response beats with ack=1 and err=wishbone_pkg::IRQ, which the bridge queues in its per-channel MSI FIFO.

---
 rtl/wb_msi_io_responder_if.sv | 47 ++++
 rtl/wb_msi_io_responder.sv | 187 ++++++++++++++++++
 tb/tb_wb_msi_io_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_msi_io_responder_if.sv
// Wishbone command/response types for the 256-bit I/O bridge channel, and
// the interface bundle that carries them between bridge and responder.
//   req  : bridge master port request (cyc, stb, we, sel, adr, dat, tid)
//   resp : channel response bus (ack, err, rty, next, stall, pri, tid, dat)
// Modports: master drives req and observes resp; slave does the reverse.

package wishbone_pkg;

  typedef enum logic [1:0] {
    OKAY  = 2'd0,
    ERR   = 2'd1,
    RETRY = 2'd2,
    IRQ   = 2'd3
  } wb_err_t;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [31:0]  sel;
    logic [31:0]  adr;
    logic [255:0] dat;
    logic [12:0]  tid;
  } wb_cmd_request256_t;

  typedef struct packed {
    logic         ack;
    wb_err_t      err;
    logic         rty;
    logic         next;
    logic         stall;
    logic [3:0]   pri;
    logic [12:0]  tid;
    logic [255:0] dat;
  } wb_cmd_response256_t;

endpackage

interface wb_msi_io_responder_if;
  import wishbone_pkg::*;

  wb_cmd_request256_t  req;
  wb_cmd_response256_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/wb_msi_io_responder.sv
// Device-side Wishbone responder for one channel of the 256-bit I/O bridge.
// Serves a small 256-bit register file (CTRL, MSI_DATA, STATUS, SCRATCH) with
// byte-lane writes and originates MSI beats (ack=1, err=IRQ) on irq_i edges.
// Ports:
//   clk_i         : clock
//   rst_i         : synchronous active-low reset
//   bus           : slave modport; bus.req in from bridge, bus.resp out
//   irq_i         : level interrupt source, rising edge raises an MSI
//   msi_pending_o : an MSI is recorded and waiting to be sent
//
// state | meaning
// IDLE  | no beat on resp; decode requests, or launch a pending MSI
// ACK   | bus ack presented, held until stb drops
// MSI   | single-cycle unsolicited interrupt beat

module wb_msi_io_responder
  import wishbone_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'hFEE00000,
  parameter logic [31:0] MASK    = 32'hFFFFFF80,
  parameter int          NREG    = 4,
  parameter logic [12:0] MSI_TID = 13'h0,
  parameter logic [3:0]  MSI_PRI = 4'd8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wb_msi_io_responder_if.slave   bus,
  input  logic                   irq_i,
  output logic                   msi_pending_o
);

  // Index width; a single-register block still carries a 1-bit index of 0.
  localparam int          IDXW   = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [2:0]  NREG_L = 3'(NREG);

  localparam logic [1:0] IDX_CTRL     = 2'd0;
  localparam logic [1:0] IDX_MSI_DATA = 2'd1;
  localparam logic [1:0] IDX_STATUS   = 2'd2;
  localparam logic [1:0] IDX_SCRATCH  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    MSI  = 2'd2
  } state_t;

  state_t              state, state_next;
  wb_cmd_response256_t resp_q, resp_next;

  logic [255:0] ctrl_q, msi_data_q, scratch_q;
  logic         pending_q, overflow_q;
  logic         pending_next, overflow_next;
  logic         irq_q;

  logic         cs;
  logic [1:0]   idx;
  logic         reg_present;
  logic [255:0] rd_data;
  logic         wr_en;
  logic         status_clr;
  logic         irq_rise;
  logic         msi_en;

  assign cs       = bus.req.cyc & bus.req.stb & ((bus.req.adr & MASK) == BASE);
  assign irq_rise = irq_i & ~irq_q;
  assign msi_en   = ctrl_q[0];

  always_comb begin
    idx = '0;
    if (NREG > 1) idx[IDXW-1:0] = bus.req.adr[5 +: IDXW];
  end

  assign reg_present = ({1'b0, idx} < NREG_L);

  always_comb begin
    rd_data = '0;
    if (reg_present) begin
      case (idx)
        IDX_CTRL:     rd_data = ctrl_q;
        IDX_MSI_DATA: rd_data = msi_data_q;
        IDX_STATUS:   rd_data = {254'd0, overflow_q, pending_q};
        IDX_SCRATCH:  rd_data = scratch_q;
        default:      rd_data = '0;
      endcase
    end
  end

  // A write commits only on the IDLE->ACK decode edge, so a long-held strobe
  // writes exactly once.
  assign wr_en      = (state == IDLE) & cs & bus.req.we & reg_present;
  assign status_clr = wr_en & (idx == IDX_STATUS) & bus.req.sel[0] & bus.req.dat[1];

  function automatic logic [255:0] merge_lanes(input logic [255:0] old_val,
                                               input logic [255:0] new_val,
                                               input logic [31:0]  sel);
    logic [255:0] r;
    r = old_val;
    for (int k = 0; k < 32; k++) begin
      if (sel[k]) r[8*k +: 8] = new_val[8*k +: 8];
    end
    return r;
  endfunction

  // Pending/overflow bookkeeping. An edge landing on the MSI exit cycle
  // re-arms pending instead of counting as an overflow, since the message
  // just sent predates it.
  always_comb begin
    pending_next  = pending_q;
    overflow_next = overflow_q;
    if (status_clr) overflow_next = 1'b0;
    if (state == MSI) begin
      pending_next = irq_rise;
    end else if (irq_rise) begin
      if (pending_q) overflow_next = 1'b1;
      pending_next = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    resp_next  = resp_q;
    case (state)
      IDLE: begin
        resp_next = '0;
        if (cs) begin
          state_next    = ACK;
          resp_next.ack = 1'b1;
          resp_next.err = OKAY;
          resp_next.tid = bus.req.tid;
          resp_next.dat = bus.req.we ? 256'd0 : rd_data;
        end else if (pending_q && msi_en) begin
          state_next    = MSI;
          resp_next.ack = 1'b1;
          resp_next.err = IRQ;
          resp_next.tid = MSI_TID;
          resp_next.pri = MSI_PRI;
          resp_next.dat = msi_data_q;
        end
      end
      ACK: begin
        if (!bus.req.stb) begin
          state_next = IDLE;
          resp_next  = '0;
        end
      end
      MSI: begin
        state_next = IDLE;
        resp_next  = '0;
      end
      default: begin
        state_next = IDLE;
        resp_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      resp_q     <= '0;
      ctrl_q     <= '0;
      msi_data_q <= '0;
      scratch_q  <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state      <= state_next;
      resp_q     <= resp_next;
      irq_q      <= irq_i;
      pending_q  <= pending_next;
      overflow_q <= overflow_next;
      if (wr_en) begin
        case (idx)
          IDX_CTRL:     ctrl_q     <= merge_lanes(ctrl_q, bus.req.dat, bus.req.sel);
          IDX_MSI_DATA: msi_data_q <= merge_lanes(msi_data_q, bus.req.dat, bus.req.sel);
          IDX_SCRATCH:  scratch_q  <= merge_lanes(scratch_q, bus.req.dat, bus.req.sel);
          default: ;
        endcase
      end
    end
  end

  assign bus.resp      = resp_q;
  assign msi_pending_o = pending_q;

endmodule

// File: tb/tb_wb_msi_io_responder.sv
module tb_wb_msi_io_responder;
  import wishbone_pkg::*;

  localparam logic [31:0] BASE     = 32'hFEE00000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_MDATA  = BASE + 32'h20;
  localparam logic [31:0] A_STATUS = BASE + 32'h40;
  localparam logic [31:0] A_SCR    = BASE + 32'h60;

  typedef struct {
    string        name;
    wb_err_t      err;
    logic [255:0] dat;
    logic [12:0]  tid;
    logic [3:0]   pri;
    int           cyc;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic irq_i;
  logic msi_pending_o;

  wb_msi_io_responder_if bus();

  wb_msi_io_responder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bus           (bus),
    .irq_i         (irq_i),
    .msi_pending_o (msi_pending_o)
  );

  always #5 clk_i = ~clk_i;

  int   cyc_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push_msi(input string name);
    exp_t e;
    e.name = name; e.err = IRQ; e.dat = 256'h1234; e.tid = 13'h0; e.pri = 4'd8; e.cyc = -1;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising ack is one beat, matched against the queue.
  logic prev_ack = 1'b0;
  logic msi_seen = 1'b0;
  always @(negedge clk_i) begin
    exp_t e;
    if (msi_seen) begin
      vectors++;
      if (bus.resp.ack !== 1'b0) begin
        miscompares++;
        $display("FAIL msi_one_cycle: ack still %b one cycle after MSI beat, expected 0", bus.resp.ack);
      end
      msi_seen = 1'b0;
    end
    if (bus.resp.ack === 1'b1 && prev_ack !== 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got err=%0d tid=%h dat=%h, expected no beat",
                 bus.resp.err, bus.resp.tid, bus.resp.dat);
      end else begin
        e = exp_q.pop_front();
        if (bus.resp.err !== e.err || bus.resp.dat !== e.dat || bus.resp.tid !== e.tid ||
            bus.resp.pri !== e.pri || bus.resp.rty !== 1'b0 || bus.resp.next !== 1'b0 ||
            bus.resp.stall !== 1'b0) begin
          miscompares++;
          $display("FAIL %s: got err=%0d tid=%h pri=%0d rty/next/stall=%b%b%b dat=%h, expected err=%0d tid=%h pri=%0d 000 dat=%h",
                   e.name, bus.resp.err, bus.resp.tid, bus.resp.pri, bus.resp.rty, bus.resp.next,
                   bus.resp.stall, bus.resp.dat, e.err, e.tid, e.pri, e.dat);
        end
        if (e.cyc >= 0) begin
          vectors++;
          if (cyc_cnt != e.cyc) begin
            miscompares++;
            $display("FAIL %s_latency: ack at cycle %0d, expected cycle %0d", e.name, cyc_cnt, e.cyc);
          end
        end
      end
      if (bus.resp.err === IRQ) msi_seen = 1'b1;
    end
    prev_ack = bus.resp.ack;
  end

  // One bus transfer; stb is held for `hold` extra cycles after the ack,
  // with req.dat inverted meanwhile so a repeated write would show up.
  task automatic bus_xfer(input string name, input logic we, input logic [31:0] adr,
                          input logic [31:0] sel, input logic [255:0] dat,
                          input logic [12:0] tid, input int hold,
                          input logic [255:0] exp_dat, input logic irq_with);
    exp_t e;
    bit   got;
    @(posedge clk_i); #1;
    bus.req.cyc = 1'b1; bus.req.stb = 1'b1; bus.req.we = we;
    bus.req.sel = sel;  bus.req.adr = adr;  bus.req.dat = dat; bus.req.tid = tid;
    if (irq_with) irq_i = 1'b1;
    e.name = name; e.err = OKAY; e.dat = we ? 256'd0 : exp_dat;
    e.tid = tid; e.pri = 4'd0; e.cyc = cyc_cnt + 1;
    exp_q.push_back(e);
    if (irq_with) push_msi({name, "_msi"});
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      irq_i = 1'b0;
      if (bus.resp.ack === 1'b1) begin got = 1; break; end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_ack_timeout: ack %b after 20 cycles, expected 1", name, bus.resp.ack);
    end
    bus.req.dat = ~dat;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      check({name, "_ack_held"}, {255'd0, bus.resp.ack}, 256'd1);
    end
    bus.req = '0;
    @(posedge clk_i); #1;
    check({name, "_resp_zero_after_drop"}, bus.resp, '0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk_i);
    @(posedge clk_i); #1;
    check({name, "_beats_outstanding"}, 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    bit got;
    exp_t e;
    rst_i = 1'b0; irq_i = 1'b0; bus.req = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_resp", bus.resp, '0);
    check("reset_pending", {255'd0, msi_pending_o}, 256'd0);
    rst_i = 1'b1;

    // Scratch write then readback, low word only.
    bus_xfer("wr_scratch", 1, A_SCR, 32'h0000000F, 256'hDEADBEEF, 13'h005, 0, '0, 0);
    bus_xfer("rd_scratch", 0, A_SCR, 32'hFFFFFFFF, '0, 13'h006, 0, 256'hDEADBEEF, 0);

    // Long strobe: write bytes 4..7, held 5 cycles, then readback.
    bus_xfer("wr_hold", 1, A_SCR, 32'h000000F0, 256'h11112222_00000000, 13'h007, 5, '0, 0);
    bus_xfer("rd_hold", 0, A_SCR, 32'hFFFFFFFF, '0, 13'h008, 4, 256'h11112222_DEADBEEF, 0);

    // Unselected address: no response at all.
    @(posedge clk_i); #1;
    bus.req.cyc = 1'b1; bus.req.stb = 1'b1; bus.req.adr = 32'hFEF00000; bus.req.sel = '1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      check("unselected_quiet", bus.resp, '0);
    end
    bus.req = '0;

    // MSI with msi_en set.
    bus_xfer("wr_ctrl", 1, A_CTRL, 32'h00000001, 256'h1, 13'h010, 0, '0, 0);
    bus_xfer("wr_mdata", 1, A_MDATA, 32'hFFFFFFFF, 256'h1234, 13'h011, 0, '0, 0);
    bus_xfer("rd_ctrl", 0, A_CTRL, 32'hFFFFFFFF, '0, 13'h012, 0, 256'h1, 0);
    @(posedge clk_i); #1;
    irq_i = 1'b1;
    push_msi("msi_basic");
    @(posedge clk_i); #1;
    irq_i = 1'b0;
    wait_drain("msi_basic");
    bus_xfer("rd_status_clear", 0, A_STATUS, 32'hFFFFFFFF, '0, 13'h013, 0, 256'h0, 0);

    // Two edges while disabled: pending + overflow, then one coalesced MSI.
    bus_xfer("wr_ctrl_off", 1, A_CTRL, 32'h00000001, 256'h0, 13'h020, 0, '0, 0);
    for (int p = 0; p < 2; p++) begin
      @(posedge clk_i); #1; irq_i = 1'b1;
      @(posedge clk_i); #1; irq_i = 1'b0;
    end
    repeat (3) @(posedge clk_i);
    #1;
    check("pending_while_disabled", {255'd0, msi_pending_o}, 256'd1);
    bus_xfer("rd_status_ovf", 0, A_STATUS, 32'hFFFFFFFF, '0, 13'h021, 0, 256'h3, 0);
    bus_xfer("wr_ctrl_on", 1, A_CTRL, 32'h00000001, 256'h1, 13'h022, 0, '0, 0);
    push_msi("msi_coalesced");
    wait_drain("msi_coalesced");
    repeat (5) @(posedge clk_i);
    bus_xfer("rd_status_ovf_only", 0, A_STATUS, 32'hFFFFFFFF, '0, 13'h023, 0, 256'h2, 0);
    bus_xfer("wr_status_w1c", 1, A_STATUS, 32'h00000001, 256'h2, 13'h024, 0, '0, 0);
    bus_xfer("rd_status_cleared", 0, A_STATUS, 32'hFFFFFFFF, '0, 13'h025, 0, 256'h0, 0);

    // IRQ edge in the same cycle as a read decode: bus ack first, MSI after.
    bus_xfer("rd_with_irq", 0, A_SCR, 32'hFFFFFFFF, '0, 13'h030, 2, 256'h11112222_DEADBEEF, 1);
    wait_drain("rd_with_irq");

    // Reset during ACK clears resp on the next edge and wipes the registers.
    @(posedge clk_i); #1;
    bus.req.cyc = 1'b1; bus.req.stb = 1'b1; bus.req.adr = A_SCR; bus.req.sel = '1;
    bus.req.tid = 13'h040;
    e.name = "rd_before_reset"; e.err = OKAY; e.dat = 256'h11112222_DEADBEEF;
    e.tid = 13'h040; e.pri = 4'd0; e.cyc = cyc_cnt + 1;
    exp_q.push_back(e);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      if (bus.resp.ack === 1'b1) begin got = 1; break; end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL rd_before_reset_ack_timeout: ack %b after 20 cycles, expected 1", bus.resp.ack);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("reset_mid_ack_resp", bus.resp, '0);
    bus.req = '0;
    rst_i = 1'b1;
    bus_xfer("rd_scratch_after_reset", 0, A_SCR, 32'hFFFFFFFF, '0, 13'h041, 0, 256'h0, 0);
    bus_xfer("rd_ctrl_after_reset", 0, A_CTRL, 32'hFFFFFFFF, '0, 13'h042, 0, 256'h0, 0);
    wait_drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
